hazard_ctrl: RTL and testbench



---
 rtl/hazard_ctrl.sv | 201 ++++++++++++++++++++
 tb/tb_hazard_ctrl.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/hazard_ctrl.sv
// Pipeline sequencer for the renas 5-stage core: stage enables/flushes, EX forwarding,
// post-reset drain, data-memory wait watchdog and stall-cycle counter.
module hazard_ctrl #(
    parameter int INIT_CYCLES = 4,
    parameter int MEM_TIMEOUT = 255,
    parameter int CNT_W       = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [4:0]       id_rs1,
    input  logic [4:0]       id_rs2,
    input  logic             id_use_rs1,
    input  logic             id_use_rs2,
    input  logic [4:0]       ex_rs1,
    input  logic [4:0]       ex_rs2,
    input  logic [4:0]       ex_rd,
    input  logic             ex_reg_wen,
    input  logic             ex_cpu_read,
    input  logic             ex_redirect,
    input  logic [4:0]       mem_rd,
    input  logic             mem_reg_wen,
    input  logic             mem_req,
    input  logic [4:0]       wb_rd,
    input  logic             wb_reg_wen,
    input  logic             imem_ready,
    input  logic             dmem_ready,
    output logic             pc_en,
    output logic             if_id_en,
    output logic             id_ex_en,
    output logic             ex_mem_en,
    output logic             mem_wb_en,
    output logic             if_id_flush,
    output logic             id_ex_flush,
    output logic             ex_mem_flush,
    output logic             mem_wb_flush,
    output logic [1:0]       fwd_a,
    output logic [1:0]       fwd_b,
    output logic             mem_timeout,
    output logic [1:0]       ctrl_state,
    output logic [CNT_W-1:0] stall_cnt
);

    localparam int IW = (INIT_CYCLES > 1) ? $clog2(INIT_CYCLES) : 1;
    localparam int WW = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
    localparam logic [IW-1:0] INIT_LAST = IW'(INIT_CYCLES - 1);
    localparam logic [WW-1:0] WAIT_LAST = WW'((MEM_TIMEOUT > 0) ? (MEM_TIMEOUT - 1) : 0);
    localparam bit            WDOG_EN   = (MEM_TIMEOUT != 0);

    typedef enum logic [1:0] {
        ST_INIT = 2'b00,
        ST_RUN  = 2'b01,
        ST_WAIT = 2'b10
    } state_t;

    state_t            state;
    logic [IW-1:0]     init_cnt;
    logic [WW-1:0]     wait_cnt;
    logic [CNT_W-1:0]  stall_q;

    logic              dstall;
    logic              load_use;
    logic              timeout_hit;
    logic [4:0]        run_en;   // {pc, if_id, id_ex, ex_mem, mem_wb}
    logic [3:0]        run_fl;   // {if_id, id_ex, ex_mem, mem_wb}
    logic [4:0]        en;
    logic [3:0]        fl;
    logic              timeout_now;

    // Hazard detection and the RUN-state response to redirect / load-use / fetch wait
    always_comb begin
        dstall      = mem_req & ~dmem_ready;
        load_use    = ex_cpu_read & ex_reg_wen & (ex_rd != 5'd0) &
                      ((id_use_rs1 & (id_rs1 == ex_rd)) | (id_use_rs2 & (id_rs2 == ex_rd)));
        timeout_hit = WDOG_EN & (wait_cnt == WAIT_LAST);
        run_en      = 5'b11111;
        run_fl      = 4'b0000;
        if (ex_redirect) begin
            run_fl = 4'b1100;
        end else if (load_use) begin
            run_en = 5'b00111;
            run_fl = 4'b0100;
        end else if (!imem_ready) begin
            run_en = 5'b01111;
            run_fl = 4'b1000;
        end else begin
            run_en = 5'b11111;
            run_fl = 4'b0000;
        end
    end

    // Mealy enables/flushes/timeout from the registered state and current inputs
    always_comb begin
        en          = 5'b11111;
        fl          = 4'b0000;
        timeout_now = 1'b0;
        case (state)
            ST_INIT: begin
                en = 5'b00000;
                fl = 4'b1111;
            end
            ST_RUN: begin
                if (dstall) begin
                    en = 5'b00000;
                end else begin
                    en = run_en;
                    fl = run_fl;
                end
            end
            ST_WAIT: begin
                // EX fields are frozen during the wait, so a pending redirect lands here at exit
                if (dmem_ready) begin
                    en = run_en;
                    fl = run_fl;
                end else if (timeout_hit) begin
                    en          = 5'b00000;
                    fl          = 4'b1111;
                    timeout_now = 1'b1;
                end else begin
                    en = 5'b00000;
                end
            end
            default: begin
                en = 5'b00000;
                fl = 4'b1111;
            end
        endcase
    end

    // Operand forwarding: the younger MEM result wins over WB
    always_comb begin
        fwd_a = 2'b00;
        fwd_b = 2'b00;
        if (mem_reg_wen && (mem_rd != 5'd0) && (mem_rd == ex_rs1)) begin
            fwd_a = 2'b01;
        end else if (wb_reg_wen && (wb_rd != 5'd0) && (wb_rd == ex_rs1)) begin
            fwd_a = 2'b10;
        end else begin
            fwd_a = 2'b00;
        end
        if (mem_reg_wen && (mem_rd != 5'd0) && (mem_rd == ex_rs2)) begin
            fwd_b = 2'b01;
        end else if (wb_reg_wen && (wb_rd != 5'd0) && (wb_rd == ex_rs2)) begin
            fwd_b = 2'b10;
        end else begin
            fwd_b = 2'b00;
        end
    end

    // Sequencer state with drain and wait counters
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= ST_INIT;
            init_cnt <= '0;
            wait_cnt <= '0;
        end else begin
            case (state)
                ST_INIT: begin
                    if (init_cnt == INIT_LAST) begin
                        state    <= ST_RUN;
                        init_cnt <= '0;
                    end else begin
                        init_cnt <= init_cnt + IW'(1);
                    end
                end
                ST_RUN: begin
                    if (dstall) begin
                        state    <= ST_WAIT;
                        wait_cnt <= '0;
                    end
                end
                ST_WAIT: begin
                    if (dmem_ready || timeout_hit) begin
                        state <= ST_RUN;
                    end else begin
                        wait_cnt <= wait_cnt + WW'(1);
                    end
                end
                default: begin
                    state    <= ST_INIT;
                    init_cnt <= '0;
                end
            endcase
        end
    end

    // Saturating count of post-drain cycles in which fetch is held
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_q <= '0;
        end else if ((state != ST_INIT) && !en[4] && (stall_q != {CNT_W{1'b1}})) begin
            stall_q <= stall_q + CNT_W'(1);
        end
    end

    assign {pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en}     = en;
    assign {if_id_flush, id_ex_flush, ex_mem_flush, mem_wb_flush} = fl;
    assign mem_timeout = timeout_now;
    assign ctrl_state  = state;
    assign stall_cnt   = stall_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Scoreboard bench for hazard_ctrl: a rule-level reference model queues expected outputs per
// cycle and an independent negedge monitor compares them with the DUT.
module tb_hazard_ctrl;

    localparam int INIT_CYCLES = 4;
    localparam int MEM_TIMEOUT = 8;
    localparam int CNT_W       = 6;
    localparam int MAX_STALL   = (1 << CNT_W) - 1;

    typedef struct packed {
        logic       rst;
        logic [4:0] id_rs1;
        logic [4:0] id_rs2;
        logic       id_use_rs1;
        logic       id_use_rs2;
        logic [4:0] ex_rs1;
        logic [4:0] ex_rs2;
        logic [4:0] ex_rd;
        logic       ex_reg_wen;
        logic       ex_cpu_read;
        logic       ex_redirect;
        logic [4:0] mem_rd;
        logic       mem_reg_wen;
        logic       mem_req;
        logic [4:0] wb_rd;
        logic       wb_reg_wen;
        logic       imem_ready;
        logic       dmem_ready;
    } stim_t;

    typedef struct packed {
        logic [4:0]       en;
        logic [3:0]       fl;
        logic [1:0]       fa;
        logic [1:0]       fb;
        logic             to;
        logic [1:0]       st;
        logic [CNT_W-1:0] sc;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    stim_t cur;
    logic pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en;
    logic if_id_flush, id_ex_flush, ex_mem_flush, mem_wb_flush;
    logic [1:0] fwd_a, fwd_b, ctrl_state;
    logic mem_timeout;
    logic [CNT_W-1:0] stall_cnt;

    hazard_ctrl #(.INIT_CYCLES(INIT_CYCLES), .MEM_TIMEOUT(MEM_TIMEOUT), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(cur.rst),
        .id_rs1(cur.id_rs1), .id_rs2(cur.id_rs2),
        .id_use_rs1(cur.id_use_rs1), .id_use_rs2(cur.id_use_rs2),
        .ex_rs1(cur.ex_rs1), .ex_rs2(cur.ex_rs2), .ex_rd(cur.ex_rd),
        .ex_reg_wen(cur.ex_reg_wen), .ex_cpu_read(cur.ex_cpu_read), .ex_redirect(cur.ex_redirect),
        .mem_rd(cur.mem_rd), .mem_reg_wen(cur.mem_reg_wen), .mem_req(cur.mem_req),
        .wb_rd(cur.wb_rd), .wb_reg_wen(cur.wb_reg_wen),
        .imem_ready(cur.imem_ready), .dmem_ready(cur.dmem_ready),
        .pc_en(pc_en), .if_id_en(if_id_en), .id_ex_en(id_ex_en), .ex_mem_en(ex_mem_en), .mem_wb_en(mem_wb_en),
        .if_id_flush(if_id_flush), .id_ex_flush(id_ex_flush), .ex_mem_flush(ex_mem_flush), .mem_wb_flush(mem_wb_flush),
        .fwd_a(fwd_a), .fwd_b(fwd_b), .mem_timeout(mem_timeout),
        .ctrl_state(ctrl_state), .stall_cnt(stall_cnt)
    );

    exp_t q[$];
    int vectors     = 0;
    int miscompares = 0;

    // Reference model: phase 0 drain, 1 running, 2 waiting on data memory
    int m_mode  = 0;
    int m_init  = 0;
    int m_wait  = 0;
    int m_stall = 0;

    function automatic logic [1:0] fwd_ref(input logic [4:0] src, input stim_t s);
        if (s.mem_reg_wen && s.mem_rd != 5'd0 && s.mem_rd == src) return 2'b01;
        if (s.wb_reg_wen && s.wb_rd != 5'd0 && s.wb_rd == src) return 2'b10;
        return 2'b00;
    endfunction

    function automatic stim_t idle();
        stim_t s;
        s = '0;
        s.imem_ready = 1'b1;
        s.dmem_ready = 1'b1;
        return s;
    endfunction

    task automatic apply(input stim_t s);
        exp_t e;
        logic [4:0] free_en;
        logic [3:0] free_fl;
        logic hit;
        int mode_now;
        @(posedge clk);
        #1;
        cur = s;
        if (s.rst) begin
            m_mode = 0; m_init = 0; m_wait = 0; m_stall = 0;
        end
        mode_now = m_mode;
        e.fa = fwd_ref(s.ex_rs1, s);
        e.fb = fwd_ref(s.ex_rs2, s);
        e.st = 2'(m_mode);
        e.sc = CNT_W'(m_stall);
        e.to = 1'b0;
        e.en = 5'b11111;
        e.fl = 4'b0000;
        hit = s.ex_cpu_read && s.ex_reg_wen && s.ex_rd != 5'd0 &&
              ((s.id_use_rs1 && s.id_rs1 == s.ex_rd) || (s.id_use_rs2 && s.id_rs2 == s.ex_rd));
        if (s.ex_redirect) begin
            free_en = 5'b11111; free_fl = 4'b1100;
        end else if (hit) begin
            free_en = 5'b00111; free_fl = 4'b0100;
        end else if (!s.imem_ready) begin
            free_en = 5'b01111; free_fl = 4'b1000;
        end else begin
            free_en = 5'b11111; free_fl = 4'b0000;
        end
        if (m_mode == 0) begin
            e.en = 5'b00000; e.fl = 4'b1111;
            if (!s.rst) begin
                if (m_init == INIT_CYCLES - 1) begin m_mode = 1; m_init = 0; end
                else m_init = m_init + 1;
            end
        end else if (m_mode == 1) begin
            if (s.mem_req && !s.dmem_ready) begin
                e.en = 5'b00000; m_mode = 2; m_wait = 0;
            end else begin
                e.en = free_en; e.fl = free_fl;
            end
        end else begin
            if (s.dmem_ready) begin
                e.en = free_en; e.fl = free_fl; m_mode = 1;
            end else if (m_wait == MEM_TIMEOUT - 1) begin
                e.en = 5'b00000; e.fl = 4'b1111; e.to = 1'b1; m_mode = 1;
            end else begin
                e.en = 5'b00000; m_wait = m_wait + 1;
            end
        end
        if (mode_now != 0 && !e.en[4] && m_stall < MAX_STALL) m_stall = m_stall + 1;
        q.push_back(e);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
        if (act !== exp_v) begin
            miscompares++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp_v);
        end
    endtask

    // Monitor: compares one queued expectation per cycle, away from the active edge
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (q.size() > 0) begin
                e = q.pop_front();
                vectors++;
                chk("enables", 32'({pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en}), 32'(e.en));
                chk("flushes", 32'({if_id_flush, id_ex_flush, ex_mem_flush, mem_wb_flush}), 32'(e.fl));
                chk("fwd_a", 32'(fwd_a), 32'(e.fa));
                chk("fwd_b", 32'(fwd_b), 32'(e.fb));
                chk("mem_timeout", 32'(mem_timeout), 32'(e.to));
                chk("ctrl_state", 32'(ctrl_state), 32'(e.st));
                chk("stall_cnt", 32'(stall_cnt), 32'(e.sc));
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

    initial begin
        stim_t s;
        cur = idle();
        cur.rst = 1'b1;
        // Reset held three cycles, then drain and run
        s = idle(); s.rst = 1'b1;
        repeat (3) apply(s);
        repeat (7) apply(idle());
        // Load-use on rs1, then the same with x0 as destination
        s = idle(); s.ex_cpu_read = 1'b1; s.ex_reg_wen = 1'b1; s.ex_rd = 5'd5;
        s.id_rs1 = 5'd5; s.id_use_rs1 = 1'b1;
        apply(s); apply(idle());
        s.ex_rd = 5'd0; s.id_rs1 = 5'd0;
        apply(s); apply(idle());
        // Forwarding priority
        s = idle(); s.ex_rs1 = 5'd7; s.ex_rs2 = 5'd7;
        s.mem_rd = 5'd7; s.wb_rd = 5'd7; s.mem_reg_wen = 1'b1; s.wb_reg_wen = 1'b1;
        apply(s);
        s.mem_reg_wen = 1'b0; apply(s);
        s.mem_rd = 5'd0; s.wb_rd = 5'd0; s.mem_reg_wen = 1'b1; apply(s);
        // Data-memory wait of three cycles
        s = idle(); s.mem_req = 1'b1; s.dmem_ready = 1'b0;
        repeat (3) apply(s);
        s.dmem_ready = 1'b1; apply(s);
        apply(idle());
        // Watchdog expiry
        s = idle(); s.mem_req = 1'b1; s.dmem_ready = 1'b0;
        repeat (MEM_TIMEOUT + 1) apply(s);
        repeat (2) apply(idle());
        // Redirect beats load-use and fetch wait
        s = idle(); s.ex_redirect = 1'b1; s.imem_ready = 1'b0;
        s.ex_cpu_read = 1'b1; s.ex_reg_wen = 1'b1; s.ex_rd = 5'd3; s.id_rs2 = 5'd3; s.id_use_rs2 = 1'b1;
        apply(s);
        s.mem_req = 1'b1; s.dmem_ready = 1'b0;
        repeat (2) apply(s);
        s.dmem_ready = 1'b1; apply(s);
        apply(idle());
        // Reset in the middle of a memory wait
        s = idle(); s.mem_req = 1'b1; s.dmem_ready = 1'b0;
        repeat (3) apply(s);
        s.rst = 1'b1; apply(s);
        repeat (6) apply(idle());
        // Randomised traffic, including sporadic resets and counter saturation
        for (int i = 0; i < 3000; i++) begin
            s.rst         = ($urandom_range(0, 399) == 0);
            s.id_rs1      = 5'($urandom_range(0, 3));
            s.id_rs2      = 5'($urandom_range(0, 3));
            s.id_use_rs1  = 1'($urandom_range(0, 1));
            s.id_use_rs2  = 1'($urandom_range(0, 1));
            s.ex_rs1      = 5'($urandom_range(0, 3));
            s.ex_rs2      = 5'($urandom_range(0, 3));
            s.ex_rd       = 5'($urandom_range(0, 3));
            s.ex_reg_wen  = 1'($urandom_range(0, 1));
            s.ex_cpu_read = 1'($urandom_range(0, 1));
            s.ex_redirect = ($urandom_range(0, 9) == 0);
            s.mem_rd      = 5'($urandom_range(0, 3));
            s.mem_reg_wen = 1'($urandom_range(0, 1));
            s.mem_req     = ($urandom_range(0, 3) == 0);
            s.wb_rd       = 5'($urandom_range(0, 3));
            s.wb_reg_wen  = 1'($urandom_range(0, 1));
            s.imem_ready  = ($urandom_range(0, 9) < 8);
            s.dmem_ready  = ($urandom_range(0, 9) < 6);
            apply(s);
        end
        repeat (3) @(posedge clk);
        if (q.size() != 0) begin
            miscompares++;
            $display("FAIL drain: got %0d pending expectations expected 0", q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
